// File: rtl/display_scan_mux.sv
// display_scan_mux: drives four 7-segment digits over one shared segment bus.
// Each digit slot starts with a blank dead-time and then drives the digit.
// All four digit patterns are snapshotted once per frame so a frame never
// mixes old and new time values.
// Optional readback decoder: define DISPLAY_SCAN_DECODE_EN to build it.
// Without it, dec_val is tied to 4'hF and dec_err to 0.
module display_scan_mux #(
    parameter int unsigned SCAN_DIV = 8,
    parameter int unsigned DEAD_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] dp7_1,
    input  logic [6:0] dp7_2,
    input  logic [6:0] dp7_3,
    input  logic [6:0] dp7_4,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic [1:0] digit_idx,
    output logic       frame_tick,
    output logic [3:0] dec_val,
    output logic       dec_err
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);

    typedef enum logic {StBlank, StDrive} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [6:0]    snap [4];
    logic [6:0]    seg_nxt;
    logic [3:0]    an_nxt;
    logic          wrap;
    logic          go_drive;

    // Next values of the segment bus and digit enables.
    always_comb begin
        wrap     = (cnt == CNT_LAST);
        go_drive = (state == StBlank) && (cnt == DEAD_LAST);
        seg_nxt  = '0;
        an_nxt   = '0;
        if (en && !wrap) begin
            if (go_drive) begin
                an_nxt  = 4'b0001 << digit_idx;
                // Slot 0 takes the live input: snap is only being loaded on this edge.
                seg_nxt = (digit_idx == 2'd0) ? dp7_1 : snap[digit_idx];
            end else if (state == StDrive) begin
                an_nxt  = an;
                seg_nxt = seg;
            end
        end
    end

    // Slot sequencer: counter, digit index, blank/drive state, snapshot and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StBlank;
            cnt        <= '0;
            digit_idx  <= 2'd0;
            seg        <= '0;
            an         <= '0;
            frame_tick <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                snap[i] <= '0;
            end
        end else begin
            seg        <= seg_nxt;
            an         <= an_nxt;
            frame_tick <= en && go_drive && (digit_idx == 2'd0);
            if (!en) begin
                state     <= StBlank;
                cnt       <= '0;
                digit_idx <= 2'd0;
            end else if (wrap) begin
                state     <= StBlank;
                cnt       <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
                if (go_drive) begin
                    state <= StDrive;
                    if (digit_idx == 2'd0) begin
                        snap[0] <= dp7_1;
                        snap[1] <= dp7_2;
                        snap[2] <= dp7_3;
                        snap[3] <= dp7_4;
                    end
                end
            end
        end
    end

`ifdef DISPLAY_SCAN_DECODE_EN
    // Decode the pattern being loaded into seg so dec_* line up with seg.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_val <= 4'hF;
            dec_err <= 1'b0;
        end else begin
            dec_err <= 1'b0;
            case (seg_nxt)
                7'b1111110: dec_val <= 4'd0;
                7'b0110000: dec_val <= 4'd1;
                7'b1101101: dec_val <= 4'd2;
                7'b1111001: dec_val <= 4'd3;
                7'b0110011: dec_val <= 4'd4;
                7'b1011011: dec_val <= 4'd5;
                7'b1011111: dec_val <= 4'd6;
                7'b1110000: dec_val <= 4'd7;
                7'b1111111: dec_val <= 4'd8;
                7'b1111011: dec_val <= 4'd9;
                7'b0000000: dec_val <= 4'hF;
                default: begin
                    dec_val <= 4'hE;
                    dec_err <= 1'b1;
                end
            endcase
        end
    end
`else
    assign dec_val = 4'hF;
    assign dec_err = 1'b0;
`endif

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux (SCAN_DIV=8, DEAD_CYC=2).
// t<N> in tags counts rising edges since reset was released.
module tb_display_scan_mux;

    localparam logic [6:0] C0 = 7'b1111110;
    localparam logic [6:0] C1 = 7'b0110000;
    localparam logic [6:0] C2 = 7'b1101101;
    localparam logic [6:0] C3 = 7'b1111001;
    localparam logic [6:0] C5 = 7'b1011011;
    localparam logic [6:0] C7 = 7'b1110000;
    localparam logic [6:0] C9 = 7'b1111011;
    localparam logic [6:0] BAD = 7'b1000001;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [6:0] dp7_1, dp7_2, dp7_3, dp7_4;
    logic [6:0] seg;
    logic [3:0] an;
    logic [1:0] digit_idx;
    logic       frame_tick;
    logic [3:0] dec_val;
    logic       dec_err;

    int total  = 0;
    int passed = 0;

    display_scan_mux #(
        .SCAN_DIV(8),
        .DEAD_CYC(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .dp7_1     (dp7_1),
        .dp7_2     (dp7_2),
        .dp7_3     (dp7_3),
        .dp7_4     (dp7_4),
        .seg       (seg),
        .an        (an),
        .digit_idx (digit_idx),
        .frame_tick(frame_tick),
        .dec_val   (dec_val),
        .dec_err   (dec_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Expected decoder outputs depend on whether the decoder is built.
    task automatic chk_dec(input string tag, input logic [3:0] val_on, input logic err_on);
`ifdef DISPLAY_SCAN_DECODE_EN
        chk({tag, " dec_val"}, 32'(dec_val), 32'(val_on));
        chk({tag, " dec_err"}, 32'(dec_err), 32'(err_on));
`else
        chk({tag, " dec_val"}, 32'(dec_val), 32'hF);
        chk({tag, " dec_err"}, 32'(dec_err), 32'h0);
`endif
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b1;
        dp7_1 = C9;
        dp7_2 = C5;
        dp7_3 = C3;
        dp7_4 = C2;
        step(2);
        chk("reset an", 32'(an), 32'h0);
        chk("reset seg", 32'(seg), 32'h0);
        chk("reset idx", 32'(digit_idx), 32'h0);
        chk("reset tick", 32'(frame_tick), 32'h0);
        chk("reset dec_val", 32'(dec_val), 32'hF);
        chk("reset dec_err", 32'(dec_err), 32'h0);

        @(negedge clk);
        rst = 1'b0;

        // Basic scan, frame 1
        step(1);
        chk("t1 an blank", 32'(an), 32'h0);
        step(1);
        chk("t2 an", 32'(an), 32'h1);
        chk("t2 seg", 32'(seg), 32'(C9));
        chk("t2 tick", 32'(frame_tick), 32'h1);
        chk("t2 idx", 32'(digit_idx), 32'h0);
        chk_dec("t2", 4'd9, 1'b0);
        step(1);
        chk("t3 tick low", 32'(frame_tick), 32'h0);
        chk("t3 an", 32'(an), 32'h1);
        step(4);
        chk("t7 an held", 32'(an), 32'h1);
        step(1);
        chk("t8 an blank", 32'(an), 32'h0);
        chk("t8 seg blank", 32'(seg), 32'h0);
        chk("t8 idx", 32'(digit_idx), 32'h1);
        chk_dec("t8", 4'hF, 1'b0);
        step(1);
        chk("t9 an blank", 32'(an), 32'h0);
        step(1);
        chk("t10 an", 32'(an), 32'h2);
        chk("t10 seg", 32'(seg), 32'(C5));
        chk_dec("t10", 4'd5, 1'b0);
        step(8);
        chk("t18 an", 32'(an), 32'h4);
        chk("t18 seg", 32'(seg), 32'(C3));
        chk("t18 idx", 32'(digit_idx), 32'h2);

        // Tearing: new inputs mid-frame must wait for the next frame
        dp7_1 = C1;
        dp7_4 = C0;
        step(1);
        chk("t19 seg unaffected", 32'(seg), 32'(C3));
        step(7);
        chk("t26 an", 32'(an), 32'h8);
        chk("t26 seg old", 32'(seg), 32'(C2));
        step(6);
        chk("t32 an blank", 32'(an), 32'h0);
        chk("t32 idx wrap", 32'(digit_idx), 32'h0);
        step(1);
        chk("t33 tick low", 32'(frame_tick), 32'h0);
        step(1);
        chk("t34 an", 32'(an), 32'h1);
        chk("t34 seg new", 32'(seg), 32'(C1));
        chk("t34 tick period", 32'(frame_tick), 32'h1);
        chk_dec("t34", 4'd1, 1'b0);
        step(8);
        chk("t42 seg", 32'(seg), 32'(C5));
        step(8);
        chk("t50 seg", 32'(seg), 32'(C3));
        step(8);
        chk("t58 an", 32'(an), 32'h8);
        chk("t58 seg new", 32'(seg), 32'(C0));

        // Enable drop for one edge during slot 3
        step(2);
        en    = 1'b0;
        dp7_1 = C7;
        step(1);
        chk("t61 an off", 32'(an), 32'h0);
        chk("t61 seg off", 32'(seg), 32'h0);
        chk("t61 idx", 32'(digit_idx), 32'h0);
        chk("t61 tick", 32'(frame_tick), 32'h0);
        en = 1'b1;
        step(1);
        chk("t62 an blank", 32'(an), 32'h0);
        step(1);
        chk("t63 an", 32'(an), 32'h1);
        chk("t63 seg fresh", 32'(seg), 32'(C7));
        chk("t63 tick", 32'(frame_tick), 32'h1);
        step(1);

        // Asynchronous reset mid-drive, checked before any clock edge
        chk("t64 an pre-reset", 32'(an), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async an", 32'(an), 32'h0);
        chk("async seg", 32'(seg), 32'h0);
        chk("async idx", 32'(digit_idx), 32'h0);
        chk("async dec_val", 32'(dec_val), 32'hF);
        chk("async tick", 32'(frame_tick), 32'h0);

        // Non-digit pattern on slot 1
        dp7_2 = BAD;
        @(negedge clk);
        rst = 1'b0;
        step(8);
        chk("d8 an blank", 32'(an), 32'h0);
        chk_dec("d8", 4'hF, 1'b0);
        step(2);
        chk("d10 an", 32'(an), 32'h2);
        chk("d10 seg", 32'(seg), 32'(BAD));
        chk_dec("d10", 4'hE, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
